// File: rtl/forward_hazard_unit.sv
// Operand-forwarding and load-use hazard control for the 24-bit pipeline.
// Tracks in-flight destinations in EX/MEM/WB and drives the EX operand-mux selects.
module forward_hazard_unit #(
  parameter int unsigned regAddrW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idValid,
  input  logic [regAddrW-1:0] idRs1,
  input  logic [regAddrW-1:0] idRs2,
  input  logic [regAddrW-1:0] idRd,
  input  logic                idUsesRs1,
  input  logic                idUsesRs2,
  input  logic                idRegWrite,
  input  logic                idMemRead,
  input  logic                idBranchFlag,
  input  logic                idImmSrc,
  input  logic                exFlush,
  output logic                stallID,
  output logic                fa,
  output logic                branchFlagEx,
  output logic                fb,
  output logic                immSrcEx
);

  // ID/EX stage
  logic                ex_valid, ex_uses_rs1, ex_uses_rs2, ex_reg_write, ex_mem_read;
  logic                ex_branch_flag, ex_imm_src;
  logic [regAddrW-1:0] ex_rs1, ex_rs2, ex_rd;
  // EX/MEM stage
  logic                mem_valid, mem_reg_write, mem_mem_read;
  logic [regAddrW-1:0] mem_rd;
  // MEM/WB stage
  logic                wb_valid, wb_reg_write;
  logic [regAddrW-1:0] wb_rd;

  logic mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid       <= 1'b0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_uses_rs1    <= 1'b0;
      ex_uses_rs2    <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_branch_flag <= 1'b0;
      ex_imm_src     <= 1'b0;
      mem_valid      <= 1'b0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_reg_write   <= 1'b0;
    end else begin
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      wb_valid      <= mem_valid;
      wb_rd         <= mem_rd;
      wb_reg_write  <= mem_reg_write;
      // Flush or load-use stall both leave a bubble in EX; ID is re-presented on a stall.
      if (exFlush || stallID) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid       <= idValid;
        ex_rs1         <= idRs1;
        ex_rs2         <= idRs2;
        ex_rd          <= idRd;
        ex_uses_rs1    <= idUsesRs1;
        ex_uses_rs2    <= idUsesRs2;
        ex_reg_write   <= idRegWrite;
        ex_mem_read    <= idMemRead;
        ex_branch_flag <= idBranchFlag;
        ex_imm_src     <= idImmSrc;
      end
    end
  end

  // A load still in MEM has no data on AluOut, so it is excluded from the MEM match.
  always_comb begin
    mem_hit_rs1 = mem_valid & mem_reg_write & ~mem_mem_read & (mem_rd == ex_rs1);
    mem_hit_rs2 = mem_valid & mem_reg_write & ~mem_mem_read & (mem_rd == ex_rs2);
    wb_hit_rs1  = wb_valid & wb_reg_write & (wb_rd == ex_rs1);
    wb_hit_rs2  = wb_valid & wb_reg_write & (wb_rd == ex_rs2);
  end

  always_comb begin
    stallID = idValid & ~exFlush & ex_valid & ex_mem_read & ex_reg_write &
              ((idUsesRs1 & (idRs1 == ex_rd)) | (idUsesRs2 & (idRs2 == ex_rd)));
  end

  // op1 select: pc override first, then youngest producer.
  always_comb begin
    fa           = 1'b0;
    branchFlagEx = 1'b0;
    if (ex_valid) begin
      if (ex_branch_flag) begin
        branchFlagEx = 1'b1;
      end else if (ex_uses_rs1 & mem_hit_rs1) begin
        fa = 1'b1;
      end else if (ex_uses_rs1 & wb_hit_rs1) begin
        fa           = 1'b1;
        branchFlagEx = 1'b1;
      end
    end
  end

  // op2 select: immediate override first, then youngest producer.
  always_comb begin
    fb       = 1'b0;
    immSrcEx = 1'b0;
    if (ex_valid) begin
      if (ex_imm_src) begin
        immSrcEx = 1'b1;
      end else if (ex_uses_rs2 & mem_hit_rs2) begin
        fb = 1'b1;
      end else if (ex_uses_rs2 & wb_hit_rs2) begin
        fb       = 1'b1;
        immSrcEx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: EX-select expectations are queued
// when an instruction is issued and compared in the cycle it occupies EX.
module tb_forward_hazard_unit;

  localparam int unsigned AW = 4;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          u1;
    logic          u2;
    logic          rw;
    logic          mr;
    logic          bf;
    logic          imm;
    logic          flush;
  } instr_t;

  typedef struct packed {
    logic [1:0] op1;
    logic [1:0] op2;
  } sel_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          idValid, idUsesRs1, idUsesRs2, idRegWrite, idMemRead, idBranchFlag, idImmSrc, exFlush;
  logic [AW-1:0] idRs1, idRs2, idRd;
  logic          stallID, fa, branchFlagEx, fb, immSrcEx;

  sel_t exq[$];
  int   checks = 0;
  int   fails  = 0;

  forward_hazard_unit #(.regAddrW(AW)) dut (
    .clk(clk), .rst(rst),
    .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idRegWrite(idRegWrite),
    .idMemRead(idMemRead), .idBranchFlag(idBranchFlag), .idImmSrc(idImmSrc),
    .exFlush(exFlush), .stallID(stallID), .fa(fa), .branchFlagEx(branchFlagEx),
    .fb(fb), .immSrcEx(immSrcEx)
  );

  always #5 clk = ~clk;

  function automatic instr_t ins(input logic v, input int s1, input int s2, input int d,
                                 input logic u1, input logic u2, input logic rw, input logic mr,
                                 input logic bf, input logic imm, input logic fl);
    instr_t t;
    t.valid = v;  t.rs1 = AW'(s1); t.rs2 = AW'(s2); t.rd = AW'(d);
    t.u1 = u1;    t.u2 = u2;       t.rw = rw;       t.mr = mr;
    t.bf = bf;    t.imm = imm;     t.flush = fl;
    return t;
  endfunction

  function automatic instr_t nop();
    return ins(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic drive(input instr_t t);
    idValid = t.valid; idRs1 = t.rs1; idRs2 = t.rs2; idRd = t.rd;
    idUsesRs1 = t.u1; idUsesRs2 = t.u2; idRegWrite = t.rw; idMemRead = t.mr;
    idBranchFlag = t.bf; idImmSrc = t.imm; exFlush = t.flush;
  endtask

  // One pipeline cycle: present ID, check stall and current EX selects, queue next EX selects.
  task automatic cycle(input string tag, input instr_t t, input logic exp_stall,
                       input logic [1:0] nx1, input logic [1:0] nx2);
    sel_t e;
    drive(t);
    @(negedge clk);
    checks++;
    if (stallID !== exp_stall) begin
      fails++;
      $display("FAIL %s stallID: got %b want %b", tag, stallID, exp_stall);
    end
    checks++;
    if (exq.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: no EX expectation queued", tag);
    end else begin
      e = exq.pop_front();
      if ({fa, branchFlagEx} !== e.op1 || {fb, immSrcEx} !== e.op2) begin
        fails++;
        $display("FAIL %s ex_sel: got op1=%b%b op2=%b%b want op1=%b op2=%b",
                 tag, fa, branchFlagEx, fb, immSrcEx, e.op1, e.op2);
      end
    end
    exq.push_back('{op1: nx1, op2: nx2});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3; i++) cycle(tag, nop(), 1'b0, 2'b00, 2'b00);
  endtask

  task automatic restart_scoreboard();
    exq.delete();
    exq.push_back('{op1: 2'b00, op2: 2'b00});
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({stallID, fa, branchFlagEx, fb, immSrcEx} !== 5'b0) begin
      fails++;
      $display("FAIL %s outputs: got %b want 00000", tag, {stallID, fa, branchFlagEx, fb, immSrcEx});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(ins(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                1'b1, 1'b1, 1'b1, 1'(i % 2), 1'(i == 3), 1'(i == 4), 1'b0));
      @(negedge clk);
      check_outputs_zero("reset_hold");
      @(posedge clk); #1;
    end
    rst = 1'b1;
    restart_scoreboard();
    cycle("reset_rd3", ins(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    drain("reset_flow");
  endtask

  task automatic test_alu_alu();
    cycle("alu_add", ins(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    cycle("alu_sub", ins(1'b1, 3, 4, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b10, 2'b00);
    drain("alu_drain");
  endtask

  task automatic test_two_apart();
    cycle("two_w5",    ins(1'b1, 1, 2, 5,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    cycle("two_other", ins(1'b1, 8, 9, 7,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    cycle("two_read",  ins(1'b1, 10, 5, 11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b11);
    drain("two_drain");
    cycle("prio_w1",   ins(1'b1, 1, 2, 5,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    cycle("prio_w2",   ins(1'b1, 1, 2, 5,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    cycle("prio_read", ins(1'b1, 10, 5, 11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b10);
    drain("prio_drain");
  endtask

  task automatic test_load_use();
    instr_t add;
    add = ins(1'b1, 2, 3, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("lu_ldr",   ins(1'b1, 1, 0, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    cycle("lu_stall", add, 1'b1, 2'b00, 2'b00);
    cycle("lu_retry", add, 1'b0, 2'b11, 2'b00);
    drain("lu_drain");
  endtask

  task automatic test_override();
    cycle("ovr_w5",  ins(1'b1, 1, 2, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    cycle("ovr_dep", ins(1'b1, 5, 5, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0, 2'b01, 2'b01);
    drain("ovr_drain");
  endtask

  task automatic test_flush();
    cycle("fl_ldr", ins(1'b1, 1, 0, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    cycle("fl_kill", ins(1'b1, 2, 2, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, 2'b00, 2'b00);
    drain("fl_drain");
  endtask

  task automatic test_reset_mid();
    cycle("mid_w5", ins(1'b1, 1, 2, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    cycle("mid_w6", ins(1'b1, 1, 2, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    restart_scoreboard();
    cycle("mid_read", ins(1'b1, 5, 6, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'b00, 2'b00);
    drain("mid_drain");
  endtask

  initial begin
    rst = 1'b0;
    drive(nop());
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alu_alu();
    test_two_apart();
    test_load_use();
    test_override();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
